// File: rtl/mux_nx1_pipe_hs_if.sv
// Handshake bundle for mux_nx1_pipe_hs: candidate words + select in, selected word out.
// Latency: n/a (wiring only). Backpressure: in_ready/out_ready follow valid/ready rules.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface mux_nx1_pipe_hs_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_err;
    logic                    err_sticky;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid, out_err, err_sticky
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid, out_err, err_sticky
    );
endinterface

// File: rtl/mux_nx1_pipe_hs.sv
// N-input, W-bit two-stage pipelined mux; optional out-of-range select flagging via MUX_SEL_ERR_EN.
// Latency: 2 cycles from acceptance to out_valid; 1 beat/cycle; at most 2 beats buffered.
// Backpressure: in_ready = stage-1 can advance, passed through combinationally from out_ready.
module mux_nx1_pipe_hs #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_nx1_pipe_hs_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic                    s1_valid;
    logic [SEL_W-1:0]        s1_sel;
    logic [NUM_IN*WIDTH-1:0] s1_data;
    logic [WIDTH-1:0]        s1_word;

    logic                    out_valid_q;
    logic [WIDTH-1:0]        out_data_q;
    logic [SEL_W-1:0]        out_sel_q;

    logic                    s2_adv;
    logic                    s1_adv;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // Selects with no matching word fall through to the zero default.
    always_comb begin
        s1_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (s1_sel == SEL_W'(k)) begin
                s1_word = s1_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sel   <= '0;
            s1_data  <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sel  <= bus.in_sel;
                s1_data <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_data_q <= s1_word;
                out_sel_q  <= s1_sel;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

`ifdef MUX_SEL_ERR_EN
    logic in_bad;
    logic s1_bad;
    logic out_err_q;
    logic err_sticky_q;

    assign in_bad = {1'b0, bus.in_sel} >= (SEL_W+1)'(NUM_IN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bad       <= 1'b0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            if (s1_adv && bus.in_valid) begin
                s1_bad <= in_bad;
            end
            // Cleared when the output empties so the flag only ever rides with a valid beat.
            if (s2_adv) begin
                out_err_q <= s1_valid && s1_bad;
            end
            if (s1_adv && bus.in_valid && in_bad) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.out_err    = out_err_q;
    assign bus.err_sticky = err_sticky_q;
`else
    assign bus.out_err    = 1'b0;
    assign bus.err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe_hs.sv
// Bench for mux_nx1_pipe_hs: directed steps on a 4-input instance, then random traffic
// on a 3-input instance against a queue-based reference of accepted beats.
module tb_mux_nx1_pipe_hs;
`ifdef MUX_SEL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux_nx1_pipe_hs_if #(.WIDTH(8), .NUM_IN(4)) b4 ();
    mux_nx1_pipe_hs_if #(.WIDTH(8), .NUM_IN(3)) b3 ();

    mux_nx1_pipe_hs #(.WIDTH(8), .NUM_IN(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mux_nx1_pipe_hs #(.WIDTH(8), .NUM_IN(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dat;
        logic [1:0] sel;
        logic       err;
    } beat_t;

    beat_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat4(input int c);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'((c + 1) * 16 + k);
        return d;
    endfunction

    initial begin
        int    acc;
        int    cyc;
        bit    seen_bad;
        bit    hold;
        beat_t prev;
        beat_t nb;
        int    s;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        b4.in_valid = 1'b0; b4.in_sel = '0; b4.in_data = '0; b4.out_ready = 1'b1;
        b3.in_valid = 1'b0; b3.in_sel = '0; b3.in_data = '0; b3.out_ready = 1'b1;

        #12;
        chk("rst_vld",    b4.out_valid, 0);
        chk("rst_rdy",    b4.in_ready, 1);
        chk("rst_dat",    b4.out_data, 0);
        chk("rst_sel",    b4.out_sel, 0);
        chk("rst_err",    b4.out_err, 0);
        chk("rst_sticky", b3.err_sticky, 0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming: sel 0..3, output on cycles 2..5.
        b4.in_data = 32'h44332211;
        for (int c = 0; c < 7; c++) begin
            b4.in_valid = (c < 4);
            b4.in_sel   = 2'(c);
            #1;
            chk("stream_rdy", b4.in_ready, 1);
            if (c >= 2 && c <= 5) begin
                chk("stream_vld", b4.out_valid, 1);
                chk("stream_dat", b4.out_data, 32'((c - 1) * 8'h11));
                chk("stream_sel", b4.out_sel, 32'(c - 2));
            end else begin
                chk("stream_idle", b4.out_valid, 0);
            end
            @(negedge clk);
        end

        // Backpressure: consumer stalls for 5 cycles with the producer always valid.
        b4.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            b4.in_valid = 1'b1;
            b4.in_sel   = 2'(c % 4);
            b4.in_data  = pat4(c);
            #1;
            if (c >= 2) begin
                chk("bp_rdy_low",  b4.in_ready, 0);
                chk("bp_hold_vld", b4.out_valid, 1);
                chk("bp_hold_dat", b4.out_data, 32'h10);
            end
            if (b4.in_valid && b4.in_ready) acc++;
            @(negedge clk);
        end
        chk("bp_accepted", acc, 2);
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        #1;
        chk("bp_passthru_rdy", b4.in_ready, 1);
        chk("bp_drain0_dat", b4.out_data, 32'h10);
        chk("bp_drain0_sel", b4.out_sel, 0);
        @(negedge clk); #1;
        chk("bp_drain1_vld", b4.out_valid, 1);
        chk("bp_drain1_dat", b4.out_data, 32'h21);
        chk("bp_drain1_sel", b4.out_sel, 1);
        @(negedge clk); #1;
        chk("bp_drain_end", b4.out_valid, 0);
        @(negedge clk);

        // Inputs change right after acceptance; the captured beat must win.
        b4.in_valid = 1'b1; b4.in_sel = 2'd2; b4.in_data = 32'hDDCCBBAA;
        @(negedge clk);
        b4.in_valid = 1'b0; b4.in_sel = 2'd0; b4.in_data = 32'h55667788;
        @(negedge clk); #1;
        chk("samp_vld", b4.out_valid, 1);
        chk("samp_dat", b4.out_data, 32'hCC);
        chk("samp_sel", b4.out_sel, 2);
        @(negedge clk);

        // Out-of-range select on the 3-input instance.
        b3.in_valid = 1'b1; b3.in_sel = 2'd3; b3.in_data = 24'h332211;
        @(negedge clk);
        b3.in_sel = 2'd1;
        #1;
        chk("oor_sticky_set", b3.err_sticky, 32'(ERR_EN));
        @(negedge clk);
        b3.in_valid = 1'b0;
        #1;
        chk("oor_vld", b3.out_valid, 1);
        chk("oor_dat", b3.out_data, 0);
        chk("oor_sel", b3.out_sel, 3);
        chk("oor_err", b3.out_err, 32'(ERR_EN));
        @(negedge clk); #1;
        chk("oor_next_dat", b3.out_data, 32'h22);
        chk("oor_next_err", b3.out_err, 0);
        chk("oor_sticky_hold", b3.err_sticky, 32'(ERR_EN));
        @(negedge clk);

        // Fill both stages, then reset asynchronously between edges.
        b4.out_ready = 1'b0; b4.in_valid = 1'b1; b4.in_sel = 2'd3; b4.in_data = 32'h44332211;
        repeat (3) @(negedge clk);
        #1;
        chk("full_vld", b4.out_valid, 1);
        chk("full_rdy", b4.in_ready, 0);
        chk("full_dat", b4.out_data, 32'h44);
        rst = 1'b1;
        #1;
        chk("arst_vld",    b4.out_valid, 0);
        chk("arst_rdy",    b4.in_ready, 1);
        chk("arst_dat",    b4.out_data, 0);
        chk("arst_sticky", b3.err_sticky, 0);
        @(negedge clk);
        rst = 1'b0; b4.in_valid = 1'b0; b4.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        chk("arst_discard", b4.out_valid, 0);
        @(negedge clk);

        // Random traffic against a queue of accepted beats.
        acc = 0; cyc = 0; seen_bad = 1'b0; hold = 1'b0; prev = '0;
        while (acc < 10000 && cyc < 60000) begin
            b3.in_valid  = ($urandom_range(0, 3) != 0);
            b3.in_sel    = 2'($urandom_range(0, 3));
            b3.in_data   = 24'($urandom);
            b3.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_rdy", b3.in_ready, 32'((q.size() < 2) || b3.out_ready));
            chk("rnd_sticky", b3.err_sticky, 32'(ERR_EN && seen_bad));
            if (hold) begin
                chk("rnd_hold_vld", b3.out_valid, 1);
                chk("rnd_hold_dat", b3.out_data, 32'(prev.dat));
                chk("rnd_hold_sel", b3.out_sel, 32'(prev.sel));
                chk("rnd_hold_err", b3.out_err, 32'(prev.err));
            end
            if (b3.out_valid) begin
                chk("rnd_q_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk("rnd_dat", b3.out_data, 32'(q[0].dat));
                    chk("rnd_sel", b3.out_sel, 32'(q[0].sel));
                    chk("rnd_err", b3.out_err, 32'(q[0].err));
                    if (b3.out_ready) void'(q.pop_front());
                end
            end
            hold     = b3.out_valid && !b3.out_ready;
            prev.dat = b3.out_data;
            prev.sel = b3.out_sel;
            prev.err = b3.out_err;
            if (b3.in_valid && b3.in_ready) begin
                s      = int'(b3.in_sel);
                nb.sel = b3.in_sel;
                nb.dat = (s < 3) ? 8'((b3.in_data >> (8 * s)) & 24'hFF) : 8'h00;
                nb.err = ERR_EN && (s >= 3);
                if (s >= 3) seen_bad = 1'b1;
                q.push_back(nb);
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rnd_beats", acc, 10000);

        b3.in_valid  = 1'b0;
        b3.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (b3.out_valid && q.size() != 0) begin
                chk("drain_dat", b3.out_data, 32'(q[0].dat));
                void'(q.pop_front());
            end
            @(negedge clk);
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_vld", b3.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
